hazard_scheduler: RTL

Pipeline sequencing controller for the 5-stage RV32I core. Tracks in-flight register writers in a small EX/MEM/WB scoreboard and detects load-use hazards that forwarding cannot cover. Generates the stall, bubble and flush controls that drive Fetch, Decode and Execute (the flush and hazard inputs of Execute). Keeps stall/flush performance counters for debug watch.

---
 rtl/hazard_scheduler_pkg.sv | 39 +++
 rtl/hazard_scheduler_if.sv | 24 ++
 rtl/hazard_scheduler_scoreboard.sv | 53 +++++
 rtl/hazard_scheduler.sv | 123 ++++++++++++
 4 files changed

// File: rtl/hazard_scheduler_pkg.sv
// Shared definitions for the RV32I hazard scheduler: opcodes, FSM states,
// scoreboard entry layout and operand-use decode.
package hazard_scheduler_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      HS_RUN   = 2'd0,
      HS_STALL = 2'd1,
      HS_FLUSH = 2'd2
   } hs_state_e;

   typedef struct packed {
      logic       valid;
      logic       is_load;
      logic [4:0] rd;
   } sb_entry_t;

   // bit 0: rs0 is read, bit 1: rs1 is read
   function automatic logic [1:0] src_use(input logic [6:0] op);
      case (op)
         OP_R, OP_BRANCH, OP_STORE: src_use = 2'b11;
         OP_I, OP_LOAD, OP_JALR:    src_use = 2'b01;
         OP_LUI, OP_AUIPC, OP_JAL:  src_use = 2'b00;
         default:                   src_use = 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// Decode/Execute-facing control bundle between the pipeline and the hazard scheduler.
interface hazard_scheduler_if;
   logic       idValid;
   logic [6:0] idOpcode;
   logic [4:0] idRs0;
   logic [4:0] idRs1;
   logic [4:0] idRd;
   logic       exPcWriteEnable;
   logic       fetchStall;
   logic       decodeStall;
   logic       flush;
   logic       hazard;
   logic       issue;

   modport master (
      output idValid, idOpcode, idRs0, idRs1, idRd, exPcWriteEnable,
      input  fetchStall, decodeStall, flush, hazard, issue
   );

   modport slave (
      input  idValid, idOpcode, idRs0, idRs1, idRd, exPcWriteEnable,
      output fetchStall, decodeStall, flush, hazard, issue
   );
endinterface

// File: rtl/hazard_scheduler_scoreboard.sv
// EX/MEM/WB writer scoreboard; shifts every cycle and flags load-use hazards
// between the EX-stage load and the instruction sitting in decode.
module hazard_scoreboard
   import hazard_scheduler_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            issue,
   input  logic            id_valid,
   input  logic [6:0]      id_opcode,
   input  logic [4:0]      id_rs0,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rd,
   output logic            load_use,
   output sb_entry_t [2:0] sb_watch
);

   sb_entry_t ex_q, ex_d;
   sb_entry_t mem_q, mem_d;
   sb_entry_t wb_q, wb_d;
   logic [1:0] use_v;
   logic       rs0_hit;
   logic       rs1_hit;

   always_comb begin
      ex_d.valid   = issue;
      ex_d.is_load = (id_opcode == OP_LOAD);
      ex_d.rd      = id_rd;
      mem_d        = ex_q;
      wb_d         = mem_q;
      use_v        = src_use(id_opcode);
      rs0_hit      = use_v[0] & (id_rs0 == ex_q.rd);
      rs1_hit      = use_v[1] & (id_rs1 == ex_q.rd);
      // x0 is never a real destination, so it can never create a dependency
      load_use     = ex_q.valid & ex_q.is_load & (ex_q.rd != 5'd0) &
                     id_valid & (rs0_hit | rs1_hit);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   assign sb_watch = {wb_q, mem_q, ex_q};

endmodule

// File: rtl/hazard_scheduler.sv
// Stall/flush sequencing FSM for the 5-stage RV32I pipeline with debug counters.
//   state    | meaning
//   HS_RUN   | normal issue; redirect or load-use detected here (Mealy)
//   HS_STALL | remaining load-use bubble cycles, fetch/decode held
//   HS_FLUSH | remaining flush cycles after a taken redirect
module hazard_scheduler
   import hazard_scheduler_pkg::*;
#(
   parameter int FLUSH_CYCLES   = 2,
   parameter int LOAD_USE_STALL = 1,
   parameter int COUNT_WIDTH    = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   hazard_scheduler_if.slave      pipe,
   output logic [COUNT_WIDTH-1:0] stallCount,
   output logic [COUNT_WIDTH-1:0] flushCount,
   output sb_entry_t [2:0]        sbWatch
);

   // the detection cycle is the first cycle of each window, so the hold
   // states only cover the remaining (N-1) cycles
   localparam logic [CNT_W-1:0] FLUSH_HOLD  = CNT_W'(FLUSH_CYCLES - 2);
   localparam logic [CNT_W-1:0] STALL_HOLD  = CNT_W'(LOAD_USE_STALL - 2);
   localparam bit               FLUSH_MULTI = (FLUSH_CYCLES > 1);
   localparam bit               STALL_MULTI = (LOAD_USE_STALL > 1);

   hs_state_e              state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   hazard_q, hazard_d;
   logic [COUNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [COUNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
   logic                   stall_c;
   logic                   flush_c;
   logic                   redirect_c;
   logic                   redirect_ok;
   logic                   issue_c;
   logic                   load_use;

   // a redirect seen while reset is held must not leak out as a flush
   assign redirect_ok = pipe.exPcWriteEnable & reset;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      stall_c    = 1'b0;
      flush_c    = 1'b0;
      redirect_c = 1'b0;
      case (state_q)
         HS_RUN, HS_STALL: begin
            if (redirect_ok) begin
               flush_c    = 1'b1;
               redirect_c = 1'b1;
               if (FLUSH_MULTI) begin
                  state_d = HS_FLUSH;
                  cnt_d   = FLUSH_HOLD;
               end else begin
                  state_d = HS_RUN;
               end
            end else if (state_q == HS_STALL) begin
               stall_c = 1'b1;
               if (cnt_q == '0) state_d = HS_RUN;
               else             cnt_d   = cnt_q - 1'b1;
            end else if (load_use) begin
               stall_c = 1'b1;
               if (STALL_MULTI) begin
                  state_d = HS_STALL;
                  cnt_d   = STALL_HOLD;
               end
            end
         end
         HS_FLUSH: begin
            flush_c = 1'b1;
            if (cnt_q == '0) state_d = HS_RUN;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = HS_RUN;
      endcase

      issue_c     = pipe.idValid & ~stall_c & ~flush_c;
      hazard_d    = stall_c | flush_c;
      stall_cnt_d = stall_cnt_q + {{(COUNT_WIDTH-1){1'b0}}, stall_c};
      flush_cnt_d = flush_cnt_q + {{(COUNT_WIDTH-1){1'b0}}, redirect_c};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= HS_RUN;
         cnt_q       <= '0;
         hazard_q    <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hazard_q    <= hazard_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   hazard_scoreboard u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .issue     (issue_c),
      .id_valid  (pipe.idValid),
      .id_opcode (pipe.idOpcode),
      .id_rs0    (pipe.idRs0),
      .id_rs1    (pipe.idRs1),
      .id_rd     (pipe.idRd),
      .load_use  (load_use),
      .sb_watch  (sbWatch)
   );

   assign pipe.fetchStall  = stall_c;
   assign pipe.decodeStall = stall_c;
   assign pipe.flush       = flush_c;
   assign pipe.issue       = issue_c;
   assign pipe.hazard      = hazard_q;
   assign stallCount       = stall_cnt_q;
   assign flushCount       = flush_cnt_q;

endmodule
